lv_scan_reg_chk: RTL

Responder side of the LV scan-register BIST handshake. It checks one configuration register per request, in order from index 0 to LV_SCAN_REG_NUM-1. Each check is a serial odd-parity check of the register data against its stored parity bit. The result goes back to the BIST sequencer as an ack pulse with an error flag. The block sits between the register file (flat data and parity buses) and the LV BIST sequencer.

---
 rtl/lv_scan_reg_if.sv | 31 +++
 rtl/lv_scan_reg_chk.sv | 114 +++++++++++
 2 files changed

// File: rtl/lv_scan_reg_if.sv
// Sequencer/register-file bundle for the LV scan-register checker.
// Latency: n/a (wiring only).
// Backpressure: none; req/ack level handshake carried as plain signals.
interface lv_scan_reg_if #(
    parameter int LV_SCAN_REG_NUM = 8,
    parameter int REG_W           = 8
);
    localparam int IDX_W = $clog2(LV_SCAN_REG_NUM + 1);

    logic                             i_bist_en;
    logic                             i_scan_reg_bist_req;
    logic                             o_scan_reg_bist_ack;
    logic                             o_scan_reg_bist_err;
    logic [LV_SCAN_REG_NUM*REG_W-1:0] i_reg_data;
    logic [LV_SCAN_REG_NUM-1:0]       i_reg_par;
    logic                             i_inj_en;
    logic [IDX_W-1:0]                 o_scan_idx;
    logic                             o_scan_busy;

    // Sequencer / register-file side
    modport master (
        output i_bist_en, i_scan_reg_bist_req, i_reg_data, i_reg_par, i_inj_en,
        input  o_scan_reg_bist_ack, o_scan_reg_bist_err, o_scan_idx, o_scan_busy
    );

    // Checker side
    modport slave (
        input  i_bist_en, i_scan_reg_bist_req, i_reg_data, i_reg_par, i_inj_en,
        output o_scan_reg_bist_ack, o_scan_reg_bist_err, o_scan_idx, o_scan_busy
    );
endinterface

// File: rtl/lv_scan_reg_chk.sv
// Serial odd-parity checker for the LV scan registers, one register per request.
// Latency: req sampled at edge k -> one-cycle ack from edge k+REG_W+1.
// Backpressure: level req; waits for req release after each ack, bist_en low aborts.
module lv_scan_reg_chk #(
    parameter int LV_SCAN_REG_NUM = 8,
    parameter int REG_W           = 8,
    parameter int INJ_IDX         = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lv_scan_reg_if.slave  bus
);
    localparam int IDX_W = $clog2(LV_SCAN_REG_NUM + 1);
    localparam int CNT_W = $clog2(REG_W);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    logic [1:0]       state;
    logic [REG_W-1:0] sh;
    logic             acc;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             ack;
    logic             err;

    logic [REG_W-1:0] cap_dat;
    logic             cap_par;
    logic             inj_hit;
    logic             start;
    logic             last_bit;

    // Select the register addressed by scan_idx; a loop keeps index widths exact.
    always_comb begin
        cap_dat = '0;
        cap_par = 1'b0;
        for (int n = 0; n < LV_SCAN_REG_NUM; n++) begin
            if (scan_idx == IDX_W'(n)) begin
                cap_dat = bus.i_reg_data[n*REG_W +: REG_W];
                cap_par = bus.i_reg_par[n];
            end
        end
    end

    assign inj_hit  = bus.i_inj_en && (scan_idx == IDX_W'(INJ_IDX));
    assign start    = bus.i_scan_reg_bist_req && (scan_idx < IDX_W'(LV_SCAN_REG_NUM));
    assign last_bit = (bit_cnt == CNT_W'(REG_W - 1));

    // Checker FSM and datapath; bist_en low overrides every transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            sh       <= '0;
            acc      <= 1'b0;
            bit_cnt  <= '0;
            scan_idx <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else if (!bus.i_bist_en) begin
            state    <= ST_IDLE;
            sh       <= '0;
            acc      <= 1'b0;
            bit_cnt  <= '0;
            scan_idx <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh      <= cap_dat ^ {{(REG_W-1){1'b0}}, inj_hit};
                        acc     <= cap_par;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc     <= acc ^ sh[0];
                    sh      <= sh >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Data XOR parity must be 1 for a good odd-parity register.
                    ack   <= 1'b1;
                    err   <= ~acc;
                    state <= ST_WAIT_REL;
                    if (scan_idx != IDX_W'(LV_SCAN_REG_NUM)) begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                ST_WAIT_REL: begin
                    // Req is still high around the ack; wait for release so one req = one check.
                    if (!bus.i_scan_reg_bist_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_scan_reg_bist_ack = ack;
    assign bus.o_scan_reg_bist_err = err;
    assign bus.o_scan_idx          = scan_idx;
    assign bus.o_scan_busy         = (state == ST_SHIFT) || (state == ST_ACK);

endmodule
